control_hazard: RTL
===================

CONTROL_HAZARD -- requirements
Module: control_hazard

Interface
REQ-001 The block SHALL have parameter VLEN, default 4, range 2..16: number of elements a vector op processes in EX, one element per cycle.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 id_instr  in  14  instruction held in IF/ID: [13:10] opcode, [9:8] dest, [7:6] src1, [5:4] src2.
REQ-006 id_valid  in  1  IF/ID holds a real instruction (not a bubble).
REQ-007 id_is_vec  in  1  ID instruction is a vector op (sources and dest are vector registers).
REQ-008 id_src_en  in  2  bit0 = src1 read, bit1 = src2 read.
REQ-009 ex_dest / mem_dest  in  2 each  dest register of the instruction in EX / MEM.
REQ-010 ex_wrv, ex_wrs, mem_wrv, mem_wrs  in  1 each  vector/scalar writeback enables of EX / MEM.
REQ-011 ex_is_load  in  1  EX instruction reads data memory.
REQ-012 branch_taken  in  1  taken branch/jump resolved in MEM (sel_pcmem path).
REQ-013 pc_wr  out  1  PC update enable.
REQ-014 if_id_wr  out  1  IF/ID register load enable.
REQ-015 if_id_flush  out  1  IF/ID register loads a bubble.
REQ-016 id_ex_bubble  out  1  ID/EX register loads all-zero control (bubble).
REQ-017 vec_busy  out  1  vector op occupying EX.
REQ-018 vec_lane  out  4  element index of the vector op in EX.
REQ-019 stall_count  out  8  saturating count of stall cycles.

Function
REQ-020 The block SHALL keep registered state: fsm in {RUN, VEC, FLUSH}, lane counter, and stall_count; all outputs SHALL be combinational from registered state and current inputs (zero-cycle latency to the pipeline registers).
REQ-021 Source hazard match: for each enabled src i, hit when src_i == dest and register class matches (id_is_vec selects wrv, else wrs).
REQ-022 The block SHALL give branch_taken the highest priority in any state: if_id_flush=1, id_ex_bubble=1, pc_wr=1, lane cleared, next state FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle: if_id_flush=1, id_ex_bubble=1, pc_wr=1, if_id_wr=1; next state RUN unless branch_taken.
REQ-024 In RUN with a hazard stall: pc_wr=0, if_id_wr=0, id_ex_bubble=1, state stays RUN.
REQ-025 In RUN with id_valid & id_is_vec and no stall: the op issues (pc_wr=1, if_id_wr=1), lane loads 0, next state VEC.
REQ-026 In RUN with no stall, and no vector op issuing under REQ-025: pc_wr=1, if_id_wr=1, id_ex_bubble=0, if_id_flush=0.
REQ-027 In VEC: vec_busy=1, vec_lane=lane, pc_wr=0, if_id_wr=0, id_ex_bubble=0 (EX holds the op).
REQ-028 In VEC, lane SHALL increment each cycle; when lane==VLEN-1 the next state SHALL be RUN and lane 0. VEC SHALL last exactly VLEN cycles.
REQ-029 stall_count SHALL increment on every cycle with pc_wr=0 and SHALL saturate at 255 (no wrap).
REQ-030 Simultaneous branch_taken and a hazard in one cycle: flush wins and the hazard is not counted.
REQ-031 vec_busy=0 and vec_lane=0 in RUN and FLUSH.

Reset
REQ-032 While rst=1: fsm=RUN, lane=0, stall_count=0; outputs pc_wr=0, if_id_wr=0, if_id_flush=1, id_ex_bubble=1.
REQ-033 Reset asserted mid-VEC SHALL abort the vector op; the first cycle after deassertion is RUN.

Configuration
REQ-034 With FORWARD_EN defined, the block SHALL stall only on load-use: ex_is_load & EX match; each such hazard gives exactly one stall cycle.
REQ-035 Without FORWARD_EN, the block SHALL stall on any match against EX or MEM writers, repeating until no match remains (up to 2 cycles).

Verification
REQ-036 The bench SHALL cover these cases:
- Reset 3 cycles, then a stream of independent ops -> pc_wr=1 every cycle, stall_count=0.
- Scalar op writes dest 2, next op reads src1=2. With FORWARD_EN: no stall. Without: 2 stall cycles, stall_count=2.
- Load in EX writes dest 1, ID reads src2=1, FORWARD_EN -> exactly 1 cycle with pc_wr=0 and id_ex_bubble=1.
- Vector op issued with VLEN=4 -> vec_busy for 4 cycles, vec_lane 0,1,2,3, pc_wr=0 throughout, then RUN.
- branch_taken at vec_lane=1 -> that cycle if_id_flush=1; next cycle FLUSH; then RUN with vec_lane=0.
- Force 300 stall cycles -> stall_count holds 255.

Source files
------------

// File: rtl/control_hazard.sv
// control_hazard: hazard and stall controller for a short in-order pipeline
// (IF -> ID -> EX -> MEM) that also executes multi-cycle vector ops in EX.
//
// A vector op occupies EX for VLEN cycles, one element per cycle, while the
// front end is frozen. A taken branch resolved in MEM flushes IF/ID and
// bubbles ID/EX from any state, then spends one cycle in FLUSH.
//
// Build option:
//   FORWARD_EN  defined   : EX/MEM results are forwarded, so only a load-use
//                           dependency on the EX instruction stalls.
//               undefined : no forwarding; any dependency on an EX or MEM
//                           writer stalls until the writer has retired.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   id_instr[13:0]    IF/ID instruction: [13:10] op, [9:8] dest, [7:6] src1,
//                     [5:4] src2
//   id_valid          IF/ID holds a real instruction
//   id_is_vec         ID instruction uses vector registers
//   id_src_en[1:0]    bit0 = src1 read, bit1 = src2 read
//   ex_dest, mem_dest destination registers of EX / MEM
//   ex_wrv, ex_wrs    EX vector / scalar writeback enables
//   mem_wrv, mem_wrs  MEM vector / scalar writeback enables
//   ex_is_load        EX instruction reads data memory
//   branch_taken      taken branch/jump resolved in MEM
//   pc_wr             PC update enable
//   if_id_wr          IF/ID load enable
//   if_id_flush       IF/ID loads a bubble
//   id_ex_bubble      ID/EX loads all-zero control
//   vec_busy          vector op occupies EX
//   vec_lane[3:0]     element index of the vector op in EX
//   stall_count[7:0]  saturating count of cycles with pc_wr low
module control_hazard #(
  parameter int VLEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] id_instr,
  input  logic        id_valid,
  input  logic        id_is_vec,
  input  logic [1:0]  id_src_en,
  input  logic [1:0]  ex_dest,
  input  logic [1:0]  mem_dest,
  input  logic        ex_wrv,
  input  logic        ex_wrs,
  input  logic        mem_wrv,
  input  logic        mem_wrs,
  input  logic        ex_is_load,
  input  logic        branch_taken,
  output logic        pc_wr,
  output logic        if_id_wr,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        vec_busy,
  output logic [3:0]  vec_lane,
  output logic [7:0]  stall_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_VEC   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [3:0] LANE_LAST = 4'(VLEN - 1);
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  logic [1:0] state_q, state_d;
  logic [3:0] lane_q, lane_d;
  logic [7:0] stall_count_q, stall_count_d;

  logic [1:0] src1, src2;
  logic       ex_wr_cls, mem_wr_cls;
  logic       ex_match, mem_match;
  logic       hazard;

  // Opcode, dest and low bits are decoded elsewhere; only the sources matter here.
  // Depending on the build, some writer inputs are not consulted either.
  logic unused_inputs;
  assign unused_inputs = ^{id_instr[13:8], id_instr[3:0], ex_is_load,
                           mem_dest, mem_wrv, mem_wrs};

  assign src1 = id_instr[7:6];
  assign src2 = id_instr[5:4];

  // ---------------------------------------------------------------------------
  // Source hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    // The register file class of the ID op picks which writeback enable counts.
    ex_wr_cls  = id_is_vec ? ex_wrv : ex_wrs;
    mem_wr_cls = id_is_vec ? mem_wrv : mem_wrs;

    ex_match  = ex_wr_cls &
                ((id_src_en[0] & (src1 == ex_dest)) |
                 (id_src_en[1] & (src2 == ex_dest)));
    mem_match = mem_wr_cls &
                ((id_src_en[0] & (src1 == mem_dest)) |
                 (id_src_en[1] & (src2 == mem_dest)));

`ifdef FORWARD_EN
    // Only a load result is too late for the bypass; one bubble covers it.
    hazard = id_valid & ex_is_load & ex_match;
`else
    // Without bypassing, wait until the producer has left MEM.
    hazard = id_valid & (ex_match | mem_match);
`endif
  end

  // ---------------------------------------------------------------------------
  // Next state and pipeline controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    pc_wr         = 1'b1;
    if_id_wr      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    vec_busy      = 1'b0;
    vec_lane      = 4'd0;

    if (branch_taken) begin
      // Redirect wins over everything, including a pending hazard or vector op.
      pc_wr        = 1'b1;
      if_id_wr     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      lane_d       = 4'd0;
      state_d      = ST_FLUSH;
      if (state_q == ST_VEC) begin
        vec_busy = 1'b1;
        vec_lane = lane_q;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            pc_wr        = 1'b0;
            if_id_wr     = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_valid && id_is_vec) begin
            // Vector op moves into EX now; the front end freezes from next cycle.
            state_d = ST_VEC;
            lane_d  = 4'd0;
          end
        end

        ST_VEC: begin
          // EX keeps the op for VLEN cycles; IF/ID and PC hold.
          vec_busy = 1'b1;
          vec_lane = lane_q;
          pc_wr    = 1'b0;
          if_id_wr = 1'b0;
          if (lane_q == LANE_LAST) begin
            state_d = ST_RUN;
            lane_d  = 4'd0;
          end else begin
            lane_d = lane_q + 4'd1;
          end
        end

        ST_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = ST_RUN;
        end

        default: begin
          // Unreachable encoding: recover to RUN with a safe bubble.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = ST_RUN;
          lane_d       = 4'd0;
        end
      endcase
    end

    if (!pc_wr && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 8'd1;
    end else begin
      stall_count_d = stall_count_q;
    end

    // Reset holds the pipeline frozen with bubbles, regardless of the state
    // register, which only clears on the next edge.
    if (rst) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      vec_busy     = 1'b0;
      vec_lane     = 4'd0;
    end
  end

  assign stall_count = stall_count_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      lane_q        <= 4'd0;
      stall_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule
